// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: round-robin arbiter that merges per-requester byte streams
// into one MAC transmit stream, enforcing an inter-frame gap and a frame-length
// watchdog. Frames are never pre-empted; new requests wait for IDLE.
module mac_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IFG_BYTES       = 12,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*8-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  output logic                       tx_last_o,
  output logic                       tx_error_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, XMIT, DRAIN, IFG} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_ptr, rr_nx, grant_nx;
  logic [CW-1:0]   byte_cnt, byte_cnt_nx;
  logic [IW-1:0]   ifg_cnt, ifg_cnt_nx;
  logic [7:0]      data_nx;
  logic            valid_nx, last_nx, error_nx;

  logic            win_found;
  logic [GW-1:0]   win_id, cand;
  logic            grant_valid, grant_last;
  logic [7:0]      grant_data;

  assign grant_valid = req_valid_i[grant_id_o];
  assign grant_last  = req_last_i[grant_id_o];
  assign grant_data  = req_data_i[{grant_id_o, 3'b000} +: 8];

  // The owner is only offered ready while it holds the frame (XMIT or DRAIN).
  assign req_ready_o = (state == XMIT || state == DRAIN) ? (NUM_REQ'(1) << grant_id_o) : '0;
  assign busy_o      = (state != IDLE);

  // Round-robin search: scan from farthest to nearest so the index right after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs default to an idle, all-zero byte.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant_id_o;
    rr_nx       = rr_ptr;
    byte_cnt_nx = byte_cnt;
    ifg_cnt_nx  = ifg_cnt;
    data_nx     = '0;
    valid_nx    = 1'b0;
    last_nx     = 1'b0;
    error_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx    = win_id;
          rr_nx       = win_id;
          byte_cnt_nx = '0;
          state_nx    = XMIT;
        end
      end
      XMIT: begin
        if (grant_valid) begin
          data_nx     = grant_data;
          valid_nx    = 1'b1;
          byte_cnt_nx = byte_cnt + 1'b1;
          if (grant_last) begin
            last_nx    = 1'b1;
            ifg_cnt_nx = '0;
            state_nx   = IFG;
          end else if (byte_cnt == CW'(MAX_FRAME_BYTES - 1)) begin
            // Oversized frame: close it on the wire as errored, swallow the rest.
            last_nx  = 1'b1;
            error_nx = 1'b1;
            state_nx = DRAIN;
          end
        end else begin
          // Underrun: the owner stalled mid-frame, abort it.
          error_nx   = 1'b1;
          ifg_cnt_nx = '0;
          state_nx   = IFG;
        end
      end
      DRAIN: begin
        if (grant_valid && grant_last) begin
          ifg_cnt_nx = '0;
          state_nx   = IFG;
        end
      end
      IFG: begin
        if (ifg_cnt == IW'(IFG_BYTES - 1)) begin
          ifg_cnt_nx = '0;
          state_nx   = IDLE;
        end else begin
          ifg_cnt_nx = ifg_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any frame silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_id_o <= '0;
      rr_ptr     <= GW'(NUM_REQ - 1);
      byte_cnt   <= '0;
      ifg_cnt    <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      tx_error_o <= 1'b0;
    end else begin
      state      <= state_nx;
      grant_id_o <= grant_nx;
      rr_ptr     <= rr_nx;
      byte_cnt   <= byte_cnt_nx;
      ifg_cnt    <= ifg_cnt_nx;
      tx_data_o  <= data_nx;
      tx_valid_o <= valid_nx;
      tx_last_o  <= last_nx;
      tx_error_o <= error_nx;
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: drives per-requester frame sources and compares the
// transmit stream against a frame-level round-robin reference model.
module tb_mac_tx_arbiter;

  localparam int NUM  = 4;
  localparam int IFG  = 12;
  localparam int MAXB = 64;
  localparam int MAXF = 8;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       e;
    int         id;
    int         gap;
    bit         first;
  } ev_t;

  logic             clk;
  logic             rst;
  logic [NUM-1:0]   req_valid;
  logic [NUM*8-1:0] req_data;
  logic [NUM-1:0]   req_last;
  logic [NUM-1:0]   req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid, tx_last, tx_error, busy;
  logic [1:0]       grant_id;

  int checks = 0;
  int errors = 0;

  int         src_len[NUM][MAXF];
  int         src_stall[NUM][MAXF];
  logic [7:0] src_seed[NUM][MAXF];
  int         nfr[NUM];
  int         fi[NUM];
  int         pos[NUM];

  ev_t exp_q[$];
  int  cyc, idle_cnt, beat_cnt, rdy_cyc, rdy_gnt, first_v_cyc, last_cyc, err_cyc;

  mac_tx_arbiter #(.NUM_REQ(NUM), .IFG_BYTES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_last_o(tx_last), .tx_error_o(tx_error),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(int n, int f, int k);
    return src_seed[n][f] + 8'(k * 3);
  endfunction

  function automatic bit pending();
    bit p = 0;
    for (int n = 0; n < NUM; n++) if (fi[n] < nfr[n]) p = 1;
    return p;
  endfunction

  task automatic clear_sources();
    for (int n = 0; n < NUM; n++) begin
      nfr[n] = 0; fi[n] = 0; pos[n] = 0;
    end
  endtask

  task automatic add_frame(int n, int len, int stall);
    src_len[n][nfr[n]]   = len;
    src_stall[n][nfr[n]] = stall;
    src_seed[n][nfr[n]]  = 8'($urandom_range(0, 255));
    nfr[n]++;
  endtask

  task automatic drive_sources();
    for (int n = 0; n < NUM; n++) begin
      if (fi[n] < nfr[n] && !(src_stall[n][fi[n]] > 0 && pos[n] == src_stall[n][fi[n]])) begin
        req_valid[n]      = 1'b1;
        req_data[n*8 +: 8] = byte_of(n, fi[n], pos[n]);
        req_last[n]       = (pos[n] == src_len[n][fi[n]] - 1);
      end else begin
        req_valid[n]      = 1'b0;
        req_data[n*8 +: 8] = 8'($urandom_range(0, 255));
        req_last[n]       = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic advance(logic [NUM-1:0] xfer);
    for (int n = 0; n < NUM; n++) begin
      if (fi[n] < nfr[n]) begin
        if (xfer[n]) begin
          pos[n]++;
          if (pos[n] == src_len[n][fi[n]]) begin fi[n]++; pos[n] = 0; end
        end else if (src_stall[n][fi[n]] > 0 && pos[n] == src_stall[n][fi[n]]) begin
          fi[n]++; pos[n] = 0;
        end
      end
    end
  endtask

  task automatic push_ev(logic v, logic [7:0] d, logic l, logic e, int id, int gap, bit first);
    ev_t x;
    x.v = v; x.d = d; x.l = l; x.e = e; x.id = id; x.gap = gap; x.first = first;
    exp_q.push_back(x);
  endtask

  // Reference model: serve remaining frames round-robin from the reset pointer.
  task automatic build_expect();
    int mf[NUM];
    int lastg, prev_gap, sel, f, len, stl, c;
    bit found;
    lastg = NUM - 1;
    prev_gap = -1;
    for (int n = 0; n < NUM; n++) mf[n] = fi[n];
    for (int guard = 0; guard < NUM * MAXF; guard++) begin
      found = 0; sel = 0;
      for (int i = 1; i <= NUM; i++) begin
        c = (lastg + i) % NUM;
        if (!found && mf[c] < nfr[c]) begin found = 1; sel = c; end
      end
      if (found) begin
        f = mf[sel]; mf[sel]++; lastg = sel;
        len = src_len[sel][f]; stl = src_stall[sel][f];
        if (stl > 0) begin
          for (int k = 0; k < stl; k++)
            push_ev(1'b1, byte_of(sel, f, k), 1'b0, 1'b0, sel, (k == 0) ? prev_gap : -1, k == 0);
          push_ev(1'b0, 8'h00, 1'b0, 1'b1, sel, -1, 1'b0);
          prev_gap = IFG + 1;
        end else if (len > MAXB) begin
          for (int k = 0; k < MAXB; k++)
            push_ev(1'b1, byte_of(sel, f, k), k == MAXB - 1, k == MAXB - 1, sel,
                    (k == 0) ? prev_gap : -1, k == 0);
          prev_gap = IFG + 1 + (len - MAXB);
        end else begin
          for (int k = 0; k < len; k++)
            push_ev(1'b1, byte_of(sel, f, k), k == len - 1, 1'b0, sel, (k == 0) ? prev_gap : -1, k == 0);
          prev_gap = IFG + 1;
        end
      end
    end
  endtask

  task automatic monitor();
    ev_t e;
    if (rdy_cyc < 0 && req_ready != '0) begin rdy_cyc = cyc; rdy_gnt = int'(grant_id); end
    if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
    if (tx_last && last_cyc < 0) last_cyc = cyc;
    if (tx_error && err_cyc < 0) err_cyc = cyc;
    if (tx_valid) beat_cnt++;
    if (!tx_valid) begin
      checks++;
      if (tx_data !== 8'h00 || tx_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d data=%h last=%b required data=00 last=0", cyc, tx_data, tx_last);
      end
    end
    if (tx_valid || tx_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d valid=%b data=%h last=%b err=%b required none",
                 cyc, tx_valid, tx_data, tx_last, tx_error);
      end else begin
        e = exp_q.pop_front();
        if ({tx_valid, tx_data, tx_last, tx_error} !== {e.v, e.d, e.l, e.e}) begin
          errors++;
          $display("FAIL beat cyc=%0d got v=%b d=%h l=%b e=%b required v=%b d=%h l=%b e=%b",
                   cyc, tx_valid, tx_data, tx_last, tx_error, e.v, e.d, e.l, e.e);
        end
        if (e.gap >= 0) begin
          checks++;
          if (idle_cnt !== e.gap) begin
            errors++;
            $display("FAIL ifg_gap cyc=%0d idle=%0d required=%0d", cyc, idle_cnt, e.gap);
          end
        end
        if (e.first) begin
          checks++;
          if (grant_id !== 2'(e.id)) begin
            errors++;
            $display("FAIL grant cyc=%0d grant_id=%0d required=%0d", cyc, grant_id, e.id);
          end
        end
      end
      if (tx_last || tx_error) idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
  endtask

  task automatic step();
    logic [NUM-1:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    advance(xfer);
    drive_sources();
  endtask

  task automatic start_scenario();
    exp_q.delete();
    cyc = 0; idle_cnt = 0; beat_cnt = 0;
    rdy_cyc = -1; rdy_gnt = -1; first_v_cyc = -1; last_cyc = -1; err_cyc = -1;
  endtask

  task automatic do_reset();
    clear_sources();
    drive_sources();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < 5000) begin step(); n++; end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout left=%0d required=0", name, exp_q.size());
    end
    repeat (IFG + 20) step();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL %s_end left=%0d busy=%b ready=%b required 0/0/0", name, exp_q.size(), busy, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1; req_last = '1; req_data = {$urandom, $urandom} ;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_last, tx_error, tx_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_tx v=%b l=%b e=%b d=%h required all 0", tx_valid, tx_last, tx_error, tx_data);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b required=0", busy); end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready ready=%b required=0000", req_ready); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant grant=%0d required=0", grant_id); end
  endtask

  task automatic test_single_frame();
    do_reset(); start_scenario();
    add_frame(2, 64, 0);
    build_expect(); drive_sources();
    run_until_done("single");
    checks++;
    if (rdy_cyc !== 1 || rdy_gnt !== 2) begin
      errors++; $display("FAIL single_grant cyc=%0d id=%0d required cyc=1 id=2", rdy_cyc, rdy_gnt);
    end
    checks++;
    if (first_v_cyc !== 2) begin errors++; $display("FAIL single_first cyc=%0d required=2", first_v_cyc); end
    checks++;
    if (last_cyc !== 65) begin errors++; $display("FAIL single_last cyc=%0d required=65", last_cyc); end
    checks++;
    if (err_cyc !== -1) begin errors++; $display("FAIL single_noerr cyc=%0d required=-1", err_cyc); end
  endtask

  task automatic test_round_robin();
    do_reset(); start_scenario();
    for (int n = 0; n < NUM; n++) begin
      add_frame(n, $urandom_range(1, 63), 0);
      add_frame(n, $urandom_range(1, 63), 0);
    end
    build_expect(); drive_sources();
    run_until_done("round_robin");
    checks++;
    if (rdy_gnt !== 0) begin errors++; $display("FAIL rr_first id=%0d required=0", rdy_gnt); end
  endtask

  task automatic test_underrun();
    do_reset(); start_scenario();
    add_frame(1, 30, 10);
    add_frame(3, 8, 0);
    build_expect(); drive_sources();
    run_until_done("underrun");
    checks++;
    if (err_cyc !== 12) begin errors++; $display("FAIL underrun_err cyc=%0d required=12", err_cyc); end
  endtask

  task automatic test_watchdog();
    do_reset(); start_scenario();
    add_frame(0, 100, 0);
    add_frame(1, 5, 0);
    build_expect(); drive_sources();
    run_until_done("watchdog");
    checks++;
    if (err_cyc !== 65 || last_cyc !== 65) begin
      errors++; $display("FAIL watchdog_end err=%0d last=%0d required 65/65", err_cyc, last_cyc);
    end
  endtask

  task automatic test_random(int iter);
    int kind, len;
    do_reset(); start_scenario();
    for (int n = 0; n < NUM; n++) begin
      for (int f = $urandom_range(0, 3); f > 0; f--) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) add_frame(n, $urandom_range(65, 90), 0);
        else if (kind == 1) begin
          len = $urandom_range(5, 40);
          add_frame(n, len, $urandom_range(1, len - 1));
        end else add_frame(n, $urandom_range(1, 64), 0);
      end
    end
    build_expect(); drive_sources();
    run_until_done($sformatf("random%0d", iter));
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset(); start_scenario();
    add_frame(0, 40, 0);
    add_frame(2, 10, 0);
    add_frame(3, 12, 0);
    build_expect(); drive_sources();
    while (beat_cnt < 20 && n < 200) begin step(); n++; end
    checks++;
    if (beat_cnt < 20) begin errors++; $display("FAIL midrst_reach beats=%0d required=20", beat_cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_last, tx_error, tx_data, busy} !== 12'd0 || req_ready !== '0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_outputs v=%b l=%b e=%b d=%h busy=%b ready=%b grant=%0d required all 0",
               tx_valid, tx_last, tx_error, tx_data, busy, req_ready, grant_id);
    end
    fi[0] = nfr[0]; pos[0] = 0;
    drive_sources();
    start_scenario();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    build_expect();
    run_until_done("midrst");
    checks++;
    if (rdy_gnt !== 2) begin errors++; $display("FAIL midrst_first id=%0d required=2", rdy_gnt); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    clear_sources();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_watchdog();
    for (int i = 0; i < 4; i++) test_random(i);
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of frame requesters, range 2..8.
REQ-002 SHALL have parameter IFG_BYTES, default 12: minimum inter-frame idle byte times.
REQ-003 SHALL have parameter MAX_FRAME_BYTES, default 1522: watchdog frame-length limit in bytes.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid_i, input, NUM_REQ bits: per-requester byte valid.
REQ-007 SHALL have port req_data_i, input, NUM_REQ*8 bits: per-requester byte; requester n in bits [8n+7:8n].
REQ-008 SHALL have port req_last_i, input, NUM_REQ bits: per-requester end-of-frame marker.
REQ-009 SHALL have port req_ready_o, output, NUM_REQ bits: per-requester byte accept.
REQ-010 SHALL have port tx_data_o, output, 8 bits: byte to MAC transmit path.
REQ-011 SHALL have port tx_valid_o, output, 1 bit: tx_data_o valid.
REQ-012 SHALL have port tx_last_o, output, 1 bit: final byte of frame.
REQ-013 SHALL have port tx_error_o, output, 1 bit: frame aborted (underrun or watchdog).
REQ-014 SHALL have port grant_id_o, output, $clog2(NUM_REQ) bits: current or last granted requester.
REQ-015 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, XMIT, DRAIN, IFG.
REQ-017 In IDLE with any req_valid_i bit high, SHALL select a winner round-robin, starting the search at the index after the last grant and wrapping at NUM_REQ; it SHALL register grant_id_o and enter XMIT next cycle.
REQ-018 In XMIT and DRAIN, req_ready_o SHALL equal one-hot(grant_id_o); in all other states it SHALL be all zero; no downstream backpressure exists.
REQ-019 In XMIT, a transfer is req_valid_i[g] and req_ready_o[g]; the byte SHALL appear on tx_data_o with tx_valid_o=1 exactly one cycle later (registered outputs).
REQ-020 A transfer with req_last_i[g]=1 SHALL give tx_last_o=1 on that output byte; state SHALL go to IFG.
REQ-021 In XMIT with req_valid_i[g]=0 (underrun), SHALL drive tx_valid_o=0, tx_last_o=0, tx_error_o=1 for one cycle the next cycle and enter IFG.
REQ-022 SHALL count transferred bytes per frame in a $clog2(MAX_FRAME_BYTES+1)-bit counter cleared on grant; the transfer that makes the count equal MAX_FRAME_BYTES without req_last SHALL be output with tx_last_o=1 and tx_error_o=1, and state SHALL go to DRAIN.
REQ-023 In DRAIN, accepted bytes SHALL be discarded (tx_valid_o=0) until a transfer with req_last_i[g]=1, then IFG; valid gaps in DRAIN are not errors.
REQ-024 IFG SHALL last exactly IFG_BYTES cycles, then IDLE; the minimum idle gap from a tx_last_o/tx_error_o cycle to the next tx_valid_o is IFG_BYTES+1 cycles.
REQ-025 Requests raised during XMIT, DRAIN or IFG SHALL be held pending and arbitrated only in IDLE; a frame SHALL never be pre-empted.
REQ-026 tx_error_o and tx_last_o SHALL be single-cycle pulses; tx_data_o SHALL be 0 whenever tx_valid_o=0.

Reset
REQ-027 While rst=0, SHALL force state IDLE, all outputs 0, byte and IFG counters 0, and the round-robin pointer to NUM_REQ-1 so that requester 0 wins first.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no tx_last_o/tx_error_o pulse; after release the first grant SHALL follow REQ-017 from the reset pointer.

Verification
REQ-029 Single requester 2 sends 64-byte frame from IDLE at cycle t -> grant_id_o=2 and ready[2]=1 at t+1, first tx byte at t+2, tx_last_o with byte 64 at t+65.
REQ-030 All four requesters continuously valid -> grants in order 0,1,2,3,0; each consecutive frame separated by exactly 13 idle cycles (IFG_BYTES=12).
REQ-031 Requester 1 drops valid after 10 bytes -> 10 tx bytes, then one cycle tx_valid_o=0 and tx_error_o=1, then 12 IFG cycles, then next grant.
REQ-032 MAX_FRAME_BYTES=64, requester 0 sends 100 bytes -> 64 tx bytes, byte 64 carries tx_last_o=tx_error_o=1, remaining 36 bytes accepted but not output, IFG after byte 100.
REQ-033 rst pulled low at byte 20 of a frame with requesters 2 and 3 pending -> outputs 0 immediately; after release requester 2 is granted first.
